mem_trace_log_collector: RTL and testbench
==========================================

// Module: mem_trace_log_collector
// PURPOSE
//  Passive per-lane capture and elastic buffer that sits directly upstream of SimMemTraceLogger.
//  - Samples per-lane memory request (or response) fire events from the core-side coalescer interface.
//  - Queues each event in a per-lane FIFO.
//  - Presents FIFO heads on the flattened trace_log_* bus, lane 0 at the LSB.
//  - Pops the heads when the logger asserts trace_log_ready.
//  - Never back-pressures the monitored interface: a full lane drops the event and counts it.
// PARAMETERS
//  NUM_LANES        4    lanes monitored; width multiplier of all packed buses
//  FIFO_DEPTH       4    entries per lane FIFO; must be a power of 2, >=2
//  DATA_WIDTH       64   address and data field width per lane
//  SOURCEID_WIDTH   32   source-id field width per lane
//  LOGSIZE_WIDTH    8    log2(bytes) size field width per lane
//  MASK_LOAD_DATA   1    1: data is forced to 0 for entries with is_store=0 (request-side use)
// PORTS
//  clock               in   1                   single clock; all state on posedge
//  reset               in   1                   asynchronous, active-low reset
//  in_valid            in   NUM_LANES           per-lane fire strobe (valid&ready of the monitored channel)
//  in_source           in   SOURCEID_WIDTH*NL   per-lane source id, lane g at [SW*(g+1)-1:SW*g]
//  in_address          in   DATA_WIDTH*NL       per-lane byte address
//  in_is_store         in   NUM_LANES           per-lane store flag
//  in_size             in   LOGSIZE_WIDTH*NL    per-lane log2 size
//  in_data             in   DATA_WIDTH*NL       per-lane store or response data
//  trace_log_valid     out  NUM_LANES           per-lane head valid (FIFO non-empty)
//  trace_log_source    out  SOURCEID_WIDTH*NL   head source id
//  trace_log_address   out  DATA_WIDTH*NL       head address
//  trace_log_is_store  out  NUM_LANES           head store flag
//  trace_log_size      out  LOGSIZE_WIDTH*NL    head size
//  trace_log_data      out  DATA_WIDTH*NL       head data (masked per MASK_LOAD_DATA)
//  trace_log_ready     in   1                   logger accepts the whole presented beat
//  overflow            out  1                   sticky: any event was dropped since reset
//  drop_count          out  32                  saturating total of dropped events, all lanes
// BEHAVIOUR
//  - Reset (reset=0, async): all FIFOs emptied (pointers and counts 0).
//    - trace_log_valid=0, all trace_log_* data outputs=0.
//    - overflow=0, drop_count=0.
//    - Storage contents are don't-care but never visible, because valid=0.
//    - Reset mid-operation discards every queued event; no partial beat is presented after release.
//  - Push: on posedge, for each lane g with in_valid[g]=1 and lane not full (after same-edge pop), the entry is written at wptr.
//    - Entry = {source, address, is_store, size, data}; data is zeroed if MASK_LOAD_DATA && !is_store.
//  - Output: trace_log_* is driven from the FIFO head registers (no combinational path from in_* to outputs).
//    - An event pushed at edge N into an empty lane is visible at trace_log_valid[g] after edge N (1-cycle latency).
//  - Pop: on posedge with trace_log_ready=1, every lane with trace_log_valid[g]=1 pops one entry simultaneously.
//    - Lanes with valid=0 are unaffected.
//    - ready=0 holds all heads stable.
//    - ready is not required to wait for valid.
//  - Simultaneous push+pop on a lane: count unchanged.
//    - A full lane that pops on the same edge accepts the push; no drop occurs.
//  - Drop: in_valid[g]=1 while lane g is full and not popping means the event is discarded.
//    - overflow is set to 1 and stays at 1 until reset.
//    - drop_count += number of lanes dropping that edge (0..NUM_LANES), saturating at 32'hFFFF_FFFF.
//  - Ordering: strict per-lane FIFO order.
//    - Lanes are independent; a beat may mix entries that entered on different cycles.
//    - Timestamps are assigned downstream at pop.
//  - Pointers: log2(FIFO_DEPTH) bits, wrap naturally.
//    - Per-lane count is log2(FIFO_DEPTH)+1 bits.
//    - full = (count==FIFO_DEPTH), empty = (count==0).
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with in_valid=4'hF -> trace_log_valid=0, drop_count=0, overflow=0 throughout.
//  2 Latency: ready=1; at edge N lane1 fires src=7, addr=0x1000, store=1, size=2, data=0xAB
//      -> after edge N, trace_log_valid=4'b0010 with those fields; after edge N+1, valid=0.
//  3 Order/backpressure: ready=0; lane0 gets 3 events (addr 0x0, 0x4, 0x8); then ready=1
//      -> heads appear 0x0, 0x4, 0x8 on consecutive cycles; valid stays high while ready=0.
//  4 Full+drop: ready=0, FIFO_DEPTH=4; lane2 gets 6 events
//      -> first 4 kept, drop_count=2, overflow=1; draining yields exactly the first 4 in order.
//  5 Full+pop same edge: lane3 full, ready=1 and in_valid[3]=1 at the same edge
//      -> event accepted, count stays 4, drop_count unchanged.
//  6 Masking / mid-run reset: load with data=0xDEAD, MASK_LOAD_DATA=1 -> trace_log_data=0.
//      Assert reset with 2 entries queued -> valid drops to 0 immediately; nothing replays after release.

Source files
------------

// File: rtl/mem_trace_log_collector_if.sv
// Bundle of the monitored-event inputs and the trace-log outputs of the collector.
// Lane g sits in element [g] of each packed array, so lane 0 occupies the LSBs
// of the equivalent flattened bus.
interface mem_trace_log_collector_if #(
    parameter int NUM_LANES      = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int SOURCEID_WIDTH = 32,
    parameter int LOGSIZE_WIDTH  = 8
);
    logic [NUM_LANES-1:0]                     in_valid;
    logic [NUM_LANES-1:0][SOURCEID_WIDTH-1:0] in_source;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     in_address;
    logic [NUM_LANES-1:0]                     in_is_store;
    logic [NUM_LANES-1:0][LOGSIZE_WIDTH-1:0]  in_size;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     in_data;

    logic [NUM_LANES-1:0]                     trace_log_valid;
    logic [NUM_LANES-1:0][SOURCEID_WIDTH-1:0] trace_log_source;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     trace_log_address;
    logic [NUM_LANES-1:0]                     trace_log_is_store;
    logic [NUM_LANES-1:0][LOGSIZE_WIDTH-1:0]  trace_log_size;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]     trace_log_data;
    logic                                     trace_log_ready;

    logic                                     overflow;
    logic [31:0]                              drop_count;

    // Monitored side plus logger: drives events and ready, observes the log bus.
    modport master (
        output in_valid, in_source, in_address, in_is_store, in_size, in_data,
        output trace_log_ready,
        input  trace_log_valid, trace_log_source, trace_log_address,
        input  trace_log_is_store, trace_log_size, trace_log_data,
        input  overflow, drop_count
    );

    // Collector side.
    modport slave (
        input  in_valid, in_source, in_address, in_is_store, in_size, in_data,
        input  trace_log_ready,
        output trace_log_valid, trace_log_source, trace_log_address,
        output trace_log_is_store, trace_log_size, trace_log_data,
        output overflow, drop_count
    );
endinterface

// File: rtl/mem_trace_log_collector.sv
// Passive per-lane trace capture: every fired event is queued in its lane FIFO,
// heads are presented to the logger, and all non-empty lanes pop together on
// ready. The monitored interface is never stalled; a full lane drops and counts.

// One lane FIFO. Head outputs come straight from storage registers and are
// forced to zero while empty, so nothing stale is ever visible.
module mem_trace_log_lane #(
    parameter int FIFO_DEPTH     = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int SOURCEID_WIDTH = 32,
    parameter int LOGSIZE_WIDTH  = 8,
    parameter bit MASK_LOAD_DATA = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [SOURCEID_WIDTH-1:0] source,
    input  logic [DATA_WIDTH-1:0]     address,
    input  logic                      is_store,
    input  logic [LOGSIZE_WIDTH-1:0]  size,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      pop_req,
    output logic                      head_valid,
    output logic [SOURCEID_WIDTH-1:0] head_source,
    output logic [DATA_WIDTH-1:0]     head_address,
    output logic                      head_is_store,
    output logic [LOGSIZE_WIDTH-1:0]  head_size,
    output logic [DATA_WIDTH-1:0]     head_data,
    output logic                      drop
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [SOURCEID_WIDTH-1:0] source;
        logic [DATA_WIDTH-1:0]     address;
        logic                      is_store;
        logic [LOGSIZE_WIDTH-1:0]  size;
        logic [DATA_WIDTH-1:0]     data;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          empty, full, pop, accept;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    assign pop    = pop_req && !empty;
    // A full lane that pops on the same edge frees a slot for the new event.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Build the stored entry; loads carry no meaningful data on the request side.
    always_comb begin
        wr_entry.source   = source;
        wr_entry.address  = address;
        wr_entry.is_store = is_store;
        wr_entry.size     = size;
        wr_entry.data     = (MASK_LOAD_DATA && !is_store) ? '0 : data;
    end

    // Entry storage; contents are only exposed while count is non-zero.
    always_ff @(posedge clock) begin
        if (accept) mem[wptr] <= wr_entry;
    end

    // Pointers and occupancy; reset empties the lane instantly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head presentation, zeroed while empty.
    always_comb begin
        head = empty ? '0 : mem[rptr];
    end

    assign head_valid    = !empty;
    assign head_source   = head.source;
    assign head_address  = head.address;
    assign head_is_store = head.is_store;
    assign head_size     = head.size;
    assign head_data     = head.data;
endmodule

module mem_trace_log_collector #(
    parameter int NUM_LANES      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int SOURCEID_WIDTH = 32,
    parameter int LOGSIZE_WIDTH  = 8,
    parameter bit MASK_LOAD_DATA = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    mem_trace_log_collector_if.slave     bus
);
    logic [NUM_LANES-1:0] lane_drop;
    logic [31:0]          drops_now;
    logic [32:0]          drop_sum;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mem_trace_log_lane #(
            .FIFO_DEPTH     (FIFO_DEPTH),
            .DATA_WIDTH     (DATA_WIDTH),
            .SOURCEID_WIDTH (SOURCEID_WIDTH),
            .LOGSIZE_WIDTH  (LOGSIZE_WIDTH),
            .MASK_LOAD_DATA (MASK_LOAD_DATA)
        ) u_lane (
            .clock         (clock),
            .reset         (reset),
            .push          (bus.in_valid[g]),
            .source        (bus.in_source[g]),
            .address       (bus.in_address[g]),
            .is_store      (bus.in_is_store[g]),
            .size          (bus.in_size[g]),
            .data          (bus.in_data[g]),
            .pop_req       (bus.trace_log_ready),
            .head_valid    (bus.trace_log_valid[g]),
            .head_source   (bus.trace_log_source[g]),
            .head_address  (bus.trace_log_address[g]),
            .head_is_store (bus.trace_log_is_store[g]),
            .head_size     (bus.trace_log_size[g]),
            .head_data     (bus.trace_log_data[g]),
            .drop          (lane_drop[g])
        );
    end

    // Number of lanes dropping this edge, and the saturating running total.
    always_comb begin
        drops_now = '0;
        for (int g = 0; g < NUM_LANES; g++) begin
            drops_now = drops_now + 32'(lane_drop[g]);
        end
        drop_sum = {1'b0, bus.drop_count} + {1'b0, drops_now};
    end

    // Sticky overflow flag and drop counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.overflow   <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            if (|lane_drop) bus.overflow <= 1'b1;
            bus.drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end
endmodule

// File: tb/tb_mem_trace_log_collector.sv
// Directed bench for mem_trace_log_collector: reset, latency, ordering under
// backpressure, full/drop, full with same-edge pop, load masking, mid-run reset.
module tb_mem_trace_log_collector;
    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_trace_log_collector_if #(
        .NUM_LANES(4), .DATA_WIDTH(64), .SOURCEID_WIDTH(32), .LOGSIZE_WIDTH(8)
    ) bus ();

    mem_trace_log_collector #(
        .NUM_LANES(4), .FIFO_DEPTH(4), .DATA_WIDTH(64),
        .SOURCEID_WIDTH(32), .LOGSIZE_WIDTH(8), .MASK_LOAD_DATA(1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fire(input int g, input logic [31:0] src, input logic [63:0] addr,
                        input logic st, input logic [7:0] sz, input logic [63:0] dat);
        bus.in_valid[g]    = 1'b1;
        bus.in_source[g]   = src;
        bus.in_address[g]  = addr;
        bus.in_is_store[g] = st;
        bus.in_size[g]     = sz;
        bus.in_data[g]     = dat;
    endtask

    task automatic idle();
        bus.in_valid = '0;
    endtask

    initial begin
        reset               = 1'b0;
        bus.in_valid        = '0;
        bus.in_source       = '0;
        bus.in_address      = '0;
        bus.in_is_store     = '0;
        bus.in_size         = '0;
        bus.in_data         = '0;
        bus.trace_log_ready = 1'b0;

        // 1: reset held with all lanes firing
        for (int i = 0; i < 4; i++) fire(i, 32'(i), 64'h40 + 64'(i), 1'b1, 8'd3, 64'h55);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", 64'(bus.trace_log_valid), 64'h0);
            check("rst_drop", 64'(bus.drop_count), 64'h0);
            check("rst_ovf", 64'(bus.overflow), 64'h0);
        end
        check("rst_addr", bus.trace_log_address[0], 64'h0);
        idle();
        reset = 1'b1;
        tick();
        check("post_rst_valid", 64'(bus.trace_log_valid), 64'h0);

        // 2: single-event latency on lane 1
        bus.trace_log_ready = 1'b1;
        fire(1, 32'd7, 64'h1000, 1'b1, 8'd2, 64'hAB);
        tick();
        idle();
        check("lat_valid", 64'(bus.trace_log_valid), 64'h2);
        check("lat_src", 64'(bus.trace_log_source[1]), 64'd7);
        check("lat_addr", bus.trace_log_address[1], 64'h1000);
        check("lat_store", 64'(bus.trace_log_is_store), 64'h2);
        check("lat_size", 64'(bus.trace_log_size[1]), 64'd2);
        check("lat_data", bus.trace_log_data[1], 64'hAB);
        tick();
        check("lat_pop", 64'(bus.trace_log_valid), 64'h0);

        // 3: ordering under backpressure on lane 0
        bus.trace_log_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fire(0, 32'd1, 64'(4 * i), 1'b1, 8'd2, 64'h11);
            tick();
        end
        idle();
        check("ord_valid", 64'(bus.trace_log_valid), 64'h1);
        check("ord_head0", bus.trace_log_address[0], 64'h0);
        tick();
        check("ord_hold_valid", 64'(bus.trace_log_valid), 64'h1);
        check("ord_hold_addr", bus.trace_log_address[0], 64'h0);
        bus.trace_log_ready = 1'b1;
        tick();
        check("ord_head1", bus.trace_log_address[0], 64'h4);
        tick();
        check("ord_head2", bus.trace_log_address[0], 64'h8);
        tick();
        check("ord_empty", 64'(bus.trace_log_valid), 64'h0);

        // 4: six events into lane 2 while stalled; two are dropped
        bus.trace_log_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fire(2, 32'd2, 64'h100 + 64'(16 * i), 1'b1, 8'd3, 64'(i));
            tick();
        end
        idle();
        check("full_drop", 64'(bus.drop_count), 64'd2);
        check("full_ovf", 64'(bus.overflow), 64'h1);
        check("full_valid", 64'(bus.trace_log_valid), 64'h4);
        bus.trace_log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_drain_addr", bus.trace_log_address[2], 64'h100 + 64'(16 * i));
            check("full_drain_data", bus.trace_log_data[2], 64'(i));
            tick();
        end
        check("full_drained", 64'(bus.trace_log_valid), 64'h0);

        // 5: full lane 3 accepts a push on the same edge it pops
        bus.trace_log_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fire(3, 32'd3, 64'h200 + 64'(16 * i), 1'b1, 8'd2, 64'h0);
            tick();
        end
        idle();
        check("fp_valid", 64'(bus.trace_log_valid), 64'h8);
        bus.trace_log_ready = 1'b1;
        fire(3, 32'd3, 64'h240, 1'b1, 8'd2, 64'h0);
        tick();
        idle();
        bus.trace_log_ready = 1'b0;
        check("fp_drop_same", 64'(bus.drop_count), 64'd2);
        check("fp_head", bus.trace_log_address[3], 64'h210);
        // lane must still hold 4 entries, so a stalled push now drops
        fire(3, 32'd3, 64'h999, 1'b1, 8'd2, 64'h0);
        tick();
        idle();
        check("fp_still_full", 64'(bus.drop_count), 64'd3);
        bus.trace_log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fp_drain", bus.trace_log_address[3], 64'h210 + 64'(16 * i));
            tick();
        end
        check("fp_drained", 64'(bus.trace_log_valid), 64'h0);

        // 6: load data masking, then reset with entries queued
        bus.trace_log_ready = 1'b0;
        fire(0, 32'd9, 64'h300, 1'b0, 8'd3, 64'hDEAD);
        fire(1, 32'd9, 64'h304, 1'b1, 8'd3, 64'hDEAD);
        tick();
        idle();
        fire(0, 32'd9, 64'h308, 1'b0, 8'd3, 64'hDEAD);
        tick();
        idle();
        check("mask_valid", 64'(bus.trace_log_valid), 64'h3);
        check("mask_load", bus.trace_log_data[0], 64'h0);
        check("mask_store", bus.trace_log_data[1], 64'hDEAD);
        check("mask_flag", 64'(bus.trace_log_is_store), 64'h2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.trace_log_valid), 64'h0);
        check("mid_rst_addr", bus.trace_log_address[0], 64'h0);
        check("mid_rst_drop", 64'(bus.drop_count), 64'h0);
        check("mid_rst_ovf", 64'(bus.overflow), 64'h0);
        tick();
        reset = 1'b1;
        bus.trace_log_ready = 1'b1;
        tick();
        check("replay_none0", 64'(bus.trace_log_valid), 64'h0);
        tick();
        check("replay_none1", 64'(bus.trace_log_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
